// File: rtl/sdram_tc_pkg.sv
// Shared types and constants for the SDRAM traffic checker: FSM states,
// data-pattern mode encodings and the LFSR step used for pseudo-random data.
package sdram_tc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } tc_state_e;

  localparam logic [1:0] MODE_ADDR  = 2'd0;
  localparam logic [1:0] MODE_NADDR = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_WALK  = 2'd3;

  // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/sdram_tc_pattern_gen.sv
// Data pattern source shared by the write and read phases; reloading it at each
// phase start makes the read-back sequence identical to the written one.
module sdram_tc_pattern_gen
  import sdram_tc_pkg::*;
#(
  parameter int          ADDR_W = 32,
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'hACE1_2345
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [31:0]       index,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] data
);

  logic [31:0]       lfsr_r;
  logic [DATA_W-1:0] addr_ext_s;
  logic [DATA_W-1:0] walk_s;

  assign addr_ext_s = DATA_W'(addr);
  assign walk_s     = DATA_W'(1'b1) << (index % 32'(DATA_W));

  // LFSR state: reseeded at phase start, advanced once per accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= SEED;
    end else if (load) begin
      lfsr_r <= SEED;
    end else if (step) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // Pattern select for the current word
  always_comb begin
    data = addr_ext_s;
    case (mode)
      MODE_ADDR:  data = addr_ext_s;
      MODE_NADDR: data = ~addr_ext_s;
      MODE_LFSR:  data = DATA_W'(lfsr_r);
      MODE_WALK:  data = walk_s;
      default:    data = addr_ext_s;
    endcase
  end

endmodule

// File: rtl/sdram_traffic_checker.sv
// On-chip memory test for the sys_sdram valid/ready port: writes a pattern over an
// address window, reads it back, counts mismatches and records the first failing address.
module sdram_traffic_checker
  import sdram_tc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
  parameter int                NUM_WORDS = 1024,
  parameter logic [31:0]       SEED      = 32'hACE1_2345,
  parameter int                ERR_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  loop,
  input  logic [1:0]            mode,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [DATA_W-1:0]     o_wdata,
  output logic [DATA_W/8-1:0]   o_wstrb,
  input  logic [DATA_W-1:0]     i_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [15:0]           loop_count
);

  localparam int                STRB_W   = DATA_W / 8;
  localparam logic [31:0]       LAST_IDX = 32'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);
  localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1'b1);

  tc_state_e         state_r;
  logic [1:0]        mode_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       idx_r;
  logic              valid_r;
  logic [STRB_W-1:0] wstrb_r;
  logic              busy_r;
  logic              done_r;
  logic [ERR_W-1:0]  err_count_r;
  logic [ADDR_W-1:0] first_err_addr_r;
  logic [15:0]       loop_count_r;

  logic              accept_s;
  logic              last_s;
  logic              restart_s;
  logic              clear_s;
  logic              load_s;
  logic              mismatch_s;
  logic [DATA_W-1:0] pat_data_s;

  assign accept_s   = valid_r & i_ready;
  assign last_s     = (idx_r == LAST_IDX);
  assign load_s     = restart_s | (accept_s & last_s & (state_r == ST_WRITE));
  assign mismatch_s = accept_s & (state_r == ST_READ) & (i_rdata != pat_data_s);

  // A fresh start clears statistics; a loop restart only re-enters WRITE
  always_comb begin
    clear_s   = 1'b0;
    restart_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clear_s   = start;
        restart_s = start;
      end
      ST_DONE: begin
        clear_s   = start;
        restart_s = start | loop;
      end
      default: begin
        clear_s   = 1'b0;
        restart_s = 1'b0;
      end
    endcase
  end

  sdram_tc_pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_pattern (
    .clk   (clk),
    .rst   (rst),
    .mode  (mode_r),
    .index (idx_r),
    .addr  (addr_r),
    .load  (load_s),
    .step  (accept_s),
    .data  (pat_data_s)
  );

  // Sequencer, address/index counters and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      mode_r           <= MODE_ADDR;
      addr_r           <= {ADDR_W{1'b0}};
      idx_r            <= 32'd0;
      valid_r          <= 1'b0;
      wstrb_r          <= {STRB_W{1'b0}};
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      err_count_r      <= {ERR_W{1'b0}};
      first_err_addr_r <= {ADDR_W{1'b0}};
      loop_count_r     <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (restart_s) begin
            state_r <= ST_WRITE;
            mode_r  <= mode;
            addr_r  <= BASE_ADDR;
            idx_r   <= 32'd0;
            valid_r <= 1'b1;
            wstrb_r <= {STRB_W{1'b1}};
            busy_r  <= 1'b1;
          end
          if (clear_s) begin
            done_r           <= 1'b0;
            err_count_r      <= {ERR_W{1'b0}};
            first_err_addr_r <= {ADDR_W{1'b0}};
            loop_count_r     <= 16'd0;
          end
        end
        ST_WRITE: begin
          if (accept_s) begin
            if (last_s) begin
              state_r <= ST_READ;
              addr_r  <= BASE_ADDR;
              idx_r   <= 32'd0;
              wstrb_r <= {STRB_W{1'b0}};
            end else begin
              addr_r <= addr_r + ADDR_ONE;
              idx_r  <= idx_r + 32'd1;
            end
          end
        end
        ST_READ: begin
          if (accept_s) begin
            if (mismatch_s) begin
              if (err_count_r != {ERR_W{1'b1}}) begin
                err_count_r <= err_count_r + ERR_ONE;
              end
              if (err_count_r == {ERR_W{1'b0}}) begin
                first_err_addr_r <= addr_r;
              end
            end
            if (last_s) begin
              state_r      <= ST_DONE;
              valid_r      <= 1'b0;
              busy_r       <= 1'b0;
              done_r       <= 1'b1;
              loop_count_r <= loop_count_r + 16'd1;
            end else begin
              addr_r <= addr_r + ADDR_ONE;
              idx_r  <= idx_r + 32'd1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid        = valid_r;
  assign o_addr         = addr_r;
  assign o_wdata        = pat_data_s;
  assign o_wstrb        = wstrb_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = done_r & (err_count_r == {ERR_W{1'b0}});
  assign err_count      = err_count_r;
  assign first_err_addr = first_err_addr_r;
  assign loop_count     = loop_count_r;

endmodule
